seq_cnt_mchan: RTL and testbench
================================

Name: seq_cnt_mchan

Overview:
- Parametrised multi-channel sequence detector and counter; successor to the single-channel a/b/c/d to r DUT used under the assertion testbenches.
- Each of NCH independent channels watches for the sequence a ##1 b ##[1:MAX_GAP] c, with d as an abort.
- Counts completions per channel, flags timeouts, and supports saturating or wrapping counters.
- Sits as the DUT beneath the chapter testbench top, clocked by the testbench clock.

Parameters:
- NCH, 4, number of independent channels
- CW, 32, width of each completion counter
- MAX_GAP, 3, maximum cycles from b to c (legal range 1..255)
- SAT, 1, 1 = counter saturates at all-ones; 0 = counter wraps to 0

Ports:
- clk_top  input  1  single clock, all state on posedge
- reset_n  input  1  asynchronous active-low reset
- a  input  NCH  per-channel sequence start
- b  input  NCH  per-channel second step
- c  input  NCH  per-channel completion
- d  input  NCH  per-channel abort
- clr  input  1  synchronous clear of all counters and ovf flags
- r  output  NCH*CW  completion counts; channel i occupies bits [i*CW +: CW]
- done  output  NCH  one-cycle pulse on completion
- err  output  NCH  one-cycle pulse on timeout
- busy  output  NCH  channel not in IDLE
- ovf  output  NCH  sticky flag: counter hit saturation or wrap

Behaviour:
- Reset (reset_n low, asynchronous): all channels go to IDLE. r, done, err, busy, ovf and gap counters are 0. Behaviour is identical when reset is asserted mid-sequence.
- Per-channel FSM states: IDLE, GOT_A, WAIT_C. Each channel has a gap counter of width clog2(MAX_GAP+1).
- IDLE:
  - a=1 -> GOT_A.
  - Otherwise stay in IDLE.
  - b and c are ignored in IDLE.
- GOT_A:
  - d=1 -> IDLE.
  - b=1 -> WAIT_C, gap=1.
  - a=1 -> GOT_A (restart).
  - Otherwise -> IDLE, with no err.
- WAIT_C, in priority order:
  - d=1 -> IDLE, no done, no err (abort beats c).
  - c=1 -> done pulse next cycle. Next state is GOT_A if a=1 in the same cycle (overlapping start), else IDLE.
  - gap==MAX_GAP -> err pulse next cycle, IDLE.
  - Otherwise gap++ and stay in WAIT_C.
- Legal c window: b sampled at cycle t means c at t+1 .. t+MAX_GAP completes the sequence. With no c by t+MAX_GAP, err asserts at t+MAX_GAP+1.
- Outputs are registered:
  - done[i] and err[i] are high for exactly one cycle, the cycle after the deciding sample.
  - done and err are mutually exclusive per channel.
  - busy = (state != IDLE), registered alongside the state.
- Counter: r[i] increments in the same cycle done[i] asserts, so it is visible one cycle after c.
  - At all-ones with SAT=1: hold the value, set ovf[i].
  - At all-ones with SAT=0: wrap to 0, set ovf[i].
  - ovf is sticky until clr or reset.
- clr:
  - Zeroes every r and ovf on the next edge.
  - Takes priority over a simultaneous increment; the counter reads 0, not 1. The done pulse still occurs.
  - Does not affect FSMs.
- Channels are fully independent. No cross-channel priority or arbitration.
- All inputs are synchronous to clk_top. X on inputs is not required to be tolerated.

Test Plan:
- Basic completion, ch0, MAX_GAP=3: a@1, b@2, c@4 -> done[0]=1 at cycle 5 only; r[0]=1 from cycle 5; busy[0] high cycles 2..4; err=0.
- Timeout: a@1, b@2, no c -> err[0] pulse at cycle 6; r[0] stays 0. Then c@6 -> no done (channel in IDLE).
- Abort priority: a@1, b@2, c and d both high @3 -> no done, no err; state IDLE at 4; r[0]=0.
- Overlap and independence: ch1 a@1, b@2, c+a@3, b@4, c@5 -> done[1] at 4 and 6, r[1]=2. ch2 driven concurrently with a different pattern is unaffected.
- Saturation/wrap with CW=4:
  - SAT=1: 16 completions -> r=15, ovf=1.
  - SAT=0: 16 completions -> r=0, ovf=1.
  - clr coincident with the 17th done -> r=0, ovf=0.
- Reset mid-sequence: a@1, b@2, reset_n low @3 (between edges) -> busy, r and ovf go to 0 immediately; c@5 after release -> no done.

Source files
------------

// File: rtl/seq_cnt_mchan.sv
// Multi-channel a ##1 b ##[1:MAX_GAP] c sequence detector with per-channel completion counters.
// Every channel is independent. The d input aborts a channel's sequence, and the clr input clears all counters.
module seq_cnt_mchan #(
  parameter int unsigned NCH     = 4,
  parameter int unsigned CW      = 32,
  parameter int unsigned MAX_GAP = 3,
  parameter bit          SAT     = 1'b1
) (
  input  logic              clk_top,
  input  logic              reset_n,
  input  logic [NCH-1:0]    a,
  input  logic [NCH-1:0]    b,
  input  logic [NCH-1:0]    c,
  input  logic [NCH-1:0]    d,
  input  logic              clr,
  output logic [NCH*CW-1:0] r,
  output logic [NCH-1:0]    done,
  output logic [NCH-1:0]    err,
  output logic [NCH-1:0]    busy,
  output logic [NCH-1:0]    ovf
);

  localparam int unsigned GW = $clog2(MAX_GAP + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GOT_A  = 2'd1,
    WAIT_C = 2'd2
  } state_e;

  state_e          state_q [NCH];
  state_e          state_d [NCH];
  logic [GW-1:0]   gap_q   [NCH];
  logic [GW-1:0]   gap_d   [NCH];
  logic [CW-1:0]   cnt_q   [NCH];
  logic [CW-1:0]   cnt_d   [NCH];
  logic [NCH-1:0]  done_q, done_d;
  logic [NCH-1:0]  err_q, err_d;
  logic [NCH-1:0]  busy_q, busy_d;
  logic [NCH-1:0]  ovf_q, ovf_d;

  // State register plus all registered outputs
  always_ff @(posedge clk_top or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NCH; i++) begin
        state_q[i] <= IDLE;
        gap_q[i]   <= '0;
        cnt_q[i]   <= '0;
      end
      done_q <= '0;
      err_q  <= '0;
      busy_q <= '0;
      ovf_q  <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        state_q[i] <= state_d[i];
        gap_q[i]   <= gap_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      done_q <= done_d;
      err_q  <= err_d;
      busy_q <= busy_d;
      ovf_q  <= ovf_d;
    end
  end

  // Next-state logic; the gap counter is only meaningful while in WAIT_C
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      state_d[i] = state_q[i];
      gap_d[i]   = '0;
      unique case (state_q[i])
        IDLE: begin
          if (a[i]) state_d[i] = GOT_A;
        end
        GOT_A: begin
          if (d[i]) begin
            state_d[i] = IDLE;
          end else if (b[i]) begin
            state_d[i] = WAIT_C;
            gap_d[i]   = GW'(1);
          end else if (a[i]) begin
            state_d[i] = GOT_A;
          end else begin
            state_d[i] = IDLE;
          end
        end
        WAIT_C: begin
          if (d[i]) begin
            state_d[i] = IDLE;
          end else if (c[i]) begin
            state_d[i] = a[i] ? GOT_A : IDLE;
          end else if (gap_q[i] == GW'(MAX_GAP)) begin
            state_d[i] = IDLE;
          end else begin
            gap_d[i] = gap_q[i] + GW'(1);
          end
        end
        default: state_d[i] = IDLE;
      endcase
    end
  end

  // Output and counter logic; clr beats a coincident increment
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      done_d[i] = (state_q[i] == WAIT_C) && !d[i] && c[i];
      err_d[i]  = (state_q[i] == WAIT_C) && !d[i] && !c[i] &&
                  (gap_q[i] == GW'(MAX_GAP));
      busy_d[i] = (state_d[i] != IDLE);
      cnt_d[i]  = cnt_q[i];
      ovf_d[i]  = ovf_q[i];
      if (clr) begin
        cnt_d[i] = '0;
        ovf_d[i] = 1'b0;
      end else if (done_d[i]) begin
        if (&cnt_q[i]) begin
          ovf_d[i] = 1'b1;
          cnt_d[i] = SAT ? cnt_q[i] : '0;
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_pack
    assign r[g*CW +: CW] = cnt_q[g];
  end

  assign done = done_q;
  assign err  = err_q;
  assign busy = busy_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_seq_cnt_mchan.sv
// Self-checking bench for seq_cnt_mchan: a saturating and a wrapping instance (CW=4) share the same stimulus.
module tb_seq_cnt_mchan;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  a, b, c, d;
  logic        clr;
  logic [15:0] r, r_w;
  logic [3:0]  done, err, busy, ovf;
  logic [3:0]  done_w, err_w, busy_w, ovf_w;

  always #5 clk = ~clk;

  seq_cnt_mchan #(.NCH(4), .CW(4), .MAX_GAP(3), .SAT(1'b1)) u_sat (
    .clk_top(clk), .reset_n(rst_n), .a(a), .b(b), .c(c), .d(d), .clr(clr),
    .r(r), .done(done), .err(err), .busy(busy), .ovf(ovf)
  );

  seq_cnt_mchan #(.NCH(4), .CW(4), .MAX_GAP(3), .SAT(1'b0)) u_wrap (
    .clk_top(clk), .reset_n(rst_n), .a(a), .b(b), .c(c), .d(d), .clr(clr),
    .r(r_w), .done(done_w), .err(err_w), .busy(busy_w), .ovf(ovf_w)
  );

  typedef struct packed {
    logic [3:0]  done;
    logic [3:0]  err;
    logic [3:0]  busy;
    logic [3:0]  ovf;
    logic [3:0]  ovf_w;
    logic [15:0] r;
    logic [15:0] r_w;
  } exp_t;

  typedef struct {
    logic [3:0]  a, b, c, d;
    logic        clr;
    logic [3:0]  done, err, busy;
    logic [15:0] r;
  } vec_t;

  exp_t sb_q[$];
  vec_t tbl[27];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs, queue its expected outputs, then check after the edge
  task automatic step(input logic [3:0] ia, input logic [3:0] ib, input logic [3:0] ic,
                      input logic [3:0] id, input logic iclr, input exp_t e);
    exp_t x;
    @(negedge clk);
    a = ia; b = ib; c = ic; d = id; clr = iclr;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      chk("sb_empty", 16'd1, 16'd0);
    end else begin
      x = sb_q.pop_front();
      chk("done",   16'(done),   16'(x.done));
      chk("err",    16'(err),    16'(x.err));
      chk("busy",   16'(busy),   16'(x.busy));
      chk("ovf",    16'(ovf),    16'(x.ovf));
      chk("r",      r,           x.r);
      chk("done_w", 16'(done_w), 16'(x.done));
      chk("err_w",  16'(err_w),  16'(x.err));
      chk("ovf_w",  16'(ovf_w),  16'(x.ovf_w));
      chk("r_w",    r_w,         x.r_w);
    end
  endtask

  function automatic exp_t mk(input logic [3:0] dn, input logic [3:0] er, input logic [3:0] bs,
                              input logic [3:0] ov, input logic [3:0] ovw,
                              input logic [15:0] rs, input logic [15:0] rw);
    exp_t e;
    e.done = dn; e.err = er; e.busy = bs; e.ovf = ov; e.ovf_w = ovw; e.r = rs; e.r_w = rw;
    return e;
  endfunction

  initial begin
    logic [3:0] s3, w3, ov3;
    // a, b, c, d, clr, done, err, busy, r
    tbl = '{
      '{4'h1, 4'h0, 4'h0, 4'h0, 1'b0, 4'h0, 4'h0, 4'h1, 16'h0000},  // basic completion ch0
      '{4'h0, 4'h1, 4'h0, 4'h0, 1'b0, 4'h0, 4'h0, 4'h1, 16'h0000},
      '{4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 4'h0, 4'h0, 4'h1, 16'h0000},
      '{4'h0, 4'h0, 4'h1, 4'h0, 1'b0, 4'h1, 4'h0, 4'h0, 16'h0001},
      '{4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 4'h0, 4'h0, 4'h0, 16'h0001},
      '{4'h1, 4'h0, 4'h0, 4'h0, 1'b0, 4'h0, 4'h0, 4'h1, 16'h0001},  // timeout ch0
      '{4'h0, 4'h1, 4'h0, 4'h0, 1'b0, 4'h0, 4'h0, 4'h1, 16'h0001},
      '{4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 4'h0, 4'h0, 4'h1, 16'h0001},
      '{4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 4'h0, 4'h0, 4'h1, 16'h0001},
      '{4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 4'h0, 4'h1, 4'h0, 16'h0001},
      '{4'h0, 4'h0, 4'h1, 4'h0, 1'b0, 4'h0, 4'h0, 4'h0, 16'h0001},
      '{4'h1, 4'h0, 4'h0, 4'h0, 1'b0, 4'h0, 4'h0, 4'h1, 16'h0001},  // abort beats c
      '{4'h0, 4'h1, 4'h0, 4'h0, 1'b0, 4'h0, 4'h0, 4'h1, 16'h0001},
      '{4'h0, 4'h0, 4'h1, 4'h1, 1'b0, 4'h0, 4'h0, 4'h0, 16'h0001},
      '{4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 4'h0, 4'h0, 4'h0, 16'h0001},
      '{4'h0, 4'h8, 4'h8, 4'h0, 1'b0, 4'h0, 4'h0, 4'h0, 16'h0001},  // ch3 GOT_A exits
      '{4'h8, 4'h0, 4'h0, 4'h0, 1'b0, 4'h0, 4'h0, 4'h8, 16'h0001},
      '{4'h8, 4'h0, 4'h0, 4'h0, 1'b0, 4'h0, 4'h0, 4'h8, 16'h0001},
      '{4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 4'h0, 4'h0, 4'h0, 16'h0001},
      '{4'h8, 4'h0, 4'h0, 4'h0, 1'b0, 4'h0, 4'h0, 4'h8, 16'h0001},
      '{4'h0, 4'h0, 4'h0, 4'h8, 1'b0, 4'h0, 4'h0, 4'h0, 16'h0001},
      '{4'h6, 4'h0, 4'h0, 4'h0, 1'b0, 4'h0, 4'h0, 4'h6, 16'h0001},  // ch1 overlap, ch2 timeout
      '{4'h0, 4'h6, 4'h0, 4'h0, 1'b0, 4'h0, 4'h0, 4'h6, 16'h0001},
      '{4'h2, 4'h0, 4'h2, 4'h0, 1'b0, 4'h2, 4'h0, 4'h6, 16'h0011},
      '{4'h0, 4'h2, 4'h0, 4'h0, 1'b0, 4'h0, 4'h0, 4'h6, 16'h0011},
      '{4'h0, 4'h0, 4'h2, 4'h0, 1'b0, 4'h2, 4'h4, 4'h0, 16'h0021},
      '{4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 4'h0, 4'h0, 4'h0, 16'h0021}
    };

    rst_n = 1'b0; a = '0; b = '0; c = '0; d = '0; clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_r",    r,          16'h0000);
    chk("rst_busy", 16'(busy),  16'h0000);
    chk("rst_done", 16'(done),  16'h0000);
    chk("rst_err",  16'(err),   16'h0000);
    chk("rst_ovf",  16'(ovf),   16'h0000);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 27; i++) begin
      step(tbl[i].a, tbl[i].b, tbl[i].c, tbl[i].d, tbl[i].clr,
           mk(tbl[i].done, tbl[i].err, tbl[i].busy, 4'h0, 4'h0, tbl[i].r, tbl[i].r));
    end

    // ch3: 16 completions reach saturation or wrap, the 17th coincides with clr
    s3 = 4'h0; w3 = 4'h0; ov3 = 4'h0;
    for (int k = 1; k <= 17; k++) begin
      step(4'h8, 4'h0, 4'h0, 4'h0, 1'b0,
           mk(4'h0, 4'h0, 4'h8, ov3, ov3, {s3, 12'h021}, {w3, 12'h021}));
      step(4'h0, 4'h8, 4'h0, 4'h0, 1'b0,
           mk(4'h0, 4'h0, 4'h8, ov3, ov3, {s3, 12'h021}, {w3, 12'h021}));
      if (k == 17) begin
        step(4'h0, 4'h0, 4'h8, 4'h0, 1'b1,
             mk(4'h8, 4'h0, 4'h0, 4'h0, 4'h0, 16'h0000, 16'h0000));
      end else begin
        s3  = (k < 15) ? 4'(k) : 4'hF;
        w3  = 4'(k);
        ov3 = (k >= 16) ? 4'h8 : 4'h0;
        step(4'h0, 4'h0, 4'h8, 4'h0, 1'b0,
             mk(4'h8, 4'h0, 4'h0, ov3, ov3, {s3, 12'h021}, {w3, 12'h021}));
      end
    end

    // Reset asserted between edges in the middle of a sequence
    step(4'h1, 4'h0, 4'h0, 4'h0, 1'b0, mk(4'h0, 4'h0, 4'h1, 4'h0, 4'h0, 16'h0000, 16'h0000));
    step(4'h0, 4'h1, 4'h0, 4'h0, 1'b0, mk(4'h0, 4'h0, 4'h1, 4'h0, 4'h0, 16'h0000, 16'h0000));
    step(4'h0, 4'h0, 4'h1, 4'h0, 1'b0, mk(4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 16'h0001, 16'h0001));
    step(4'h1, 4'h0, 4'h0, 4'h0, 1'b0, mk(4'h0, 4'h0, 4'h1, 4'h0, 4'h0, 16'h0001, 16'h0001));
    step(4'h0, 4'h1, 4'h0, 4'h0, 1'b0, mk(4'h0, 4'h0, 4'h1, 4'h0, 4'h0, 16'h0001, 16'h0001));
    #2;
    a = '0; b = '0;
    rst_n = 1'b0;
    #1;
    chk("async_busy", 16'(busy), 16'h0000);
    chk("async_r",    r,         16'h0000);
    chk("async_r_w",  r_w,       16'h0000);
    chk("async_ovf",  16'(ovf),  16'h0000);
    chk("async_done", 16'(done), 16'h0000);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step(4'h0, 4'h0, 4'h1, 4'h0, 1'b0, mk(4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 16'h0000, 16'h0000));
    step(4'h0, 4'h0, 4'h0, 4'h0, 1'b0, mk(4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 16'h0000, 16'h0000));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
